// File: rtl/up_down_counter_mod_pkg.sv
// up_down_counter_mod_pkg: direction and end-of-range mode constants shared by counter designs
package up_down_counter_mod_pkg;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DOWN = 1'b0;
  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT = 1;
endpackage

// File: rtl/dff_sr_w.sv
// dff_sr_w: WIDTH-bit D register with synchronous active-high reset to zero
module dff_sr_w #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk)
    q <= rst ? '0 : d;
endmodule

// File: rtl/up_down_counter_mod.sv
// up_down_counter_mod: modulo-N up/down counter with enable, clamped load, optional saturation,
// combinational terminal count and registered wrap pulse
module up_down_counter_mod
  import up_down_counter_mod_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int MODULUS = 8,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
  localparam logic SAT = (SATURATE == MODE_SAT);
  if (MODULUS < 2 || MODULUS > 2 ** WIDTH) begin : g_bad_modulus
    $error("up_down_counter_mod: MODULUS %0d outside 2..2**WIDTH", MODULUS);
  end
  logic             at_end;
  logic [WIDTH-1:0] count_d;
  logic             wrap_d;
  always_comb begin
    at_end = (up == DIR_UP) ? (count == MAX) : (count == '0);
    tc = en & at_end;
    count_d = load ? ((load_val > MAX) ? MAX : load_val)
            : !en ? count
            : !at_end ? ((up == DIR_UP) ? count + WIDTH'(1) : count - WIDTH'(1))
            : SAT ? count
            : (up == DIR_UP) ? '0 : MAX;
    // wrap only when a range end is crossed, never on load or in saturating mode
    wrap_d = !load & tc & !SAT;
  end
  dff_sr_w #(.WIDTH(WIDTH)) u_count (.clk(clk), .rst(rst), .d(count_d), .q(count));
  dff_sr_w #(.WIDTH(1)) u_wrap (.clk(clk), .rst(rst), .d(wrap_d), .q(wrap));
endmodule
